// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift/add multiplier:
//   mult_state_t - sequencer states (IDLE, ADD, SHIFT, DONE)
//   cnt_width()  - width of an iteration counter that must hold 0..width
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  // The counter has to reach the operand width itself, hence width + 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 32'd1);
  endfunction

endpackage

// File: rtl/add_sub_ext.sv
// -----------------------------------------------------------------------------
// add_sub_ext
// WIDTH+1-bit adder/subtractor. Both operands are extended by one bit before
// the operation, so the extra result bit is either a true sign (signed) or
// the carry out (unsigned).
// Ports:
//   i_a      - WIDTH-bit first operand
//   i_b      - WIDTH-bit second operand
//   i_sub    - 1: o_sum = a - b, 0: o_sum = a + b
//   i_signed - 1: sign-extend operands, 0: zero-extend operands
//   o_sum    - WIDTH+1-bit result
// -----------------------------------------------------------------------------
module add_sub_ext #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_signed,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_b_ext;

  assign w_a_ext = {i_signed & i_a[WIDTH-1], i_a};
  assign w_b_ext = {i_signed & i_b[WIDTH-1], i_b};
  assign o_sum   = i_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

endmodule

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential WIDTH x WIDTH add/shift multiplier, signed or unsigned. The
// multiplier lives in B, the multiplicand is latched into Sreg at start, and
// the 2*WIDTH-bit product ends up in {A,B} with X as sign/carry extension.
// Each bit takes one ADD and one SHIFT cycle, so latency is fixed.
// Ports:
//   Clk          - system clock, rising edge
//   Reset        - synchronous active-high reset
//   Run          - level start request; must drop before a new start
//   ClearA_LoadB - B <= S, A <= 0, X <= 0 (only in IDLE or DONE)
//   S            - operand source
//   Aval         - register A (upper product half)
//   Bval         - register B (lower product half / multiplier)
//   X            - sign extension bit (SIGNED=1) or carry (SIGNED=0)
//   Done         - high while the result is being held
// -----------------------------------------------------------------------------
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  mult_state_t      r_state;
  mult_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic             r_x;
  logic             w_x_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_count_inc;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;

  assign w_count_inc = r_count + CW'(1);

  // The MSB of a two's-complement multiplier carries negative weight, so its
  // partial product is subtracted on the final iteration.
  assign w_sub = SIGNED && (r_count == CW'(WIDTH - 1));

  add_sub_ext #(
    .WIDTH (WIDTH)
  ) u_add_sub (
    .i_a      (r_a),
    .i_b      (r_sreg),
    .i_sub    (w_sub),
    .i_signed (SIGNED),
    .o_sum    (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_x_nxt     = r_x;
    w_sreg_nxt  = r_sreg;
    w_count_nxt = r_count;

    case (r_state)
      IDLE: begin
        if (ClearA_LoadB) begin
          w_b_nxt = S;
          w_a_nxt = '0;
          w_x_nxt = 1'b0;
        end else if (Run) begin
          // B is deliberately kept so results can be chained.
          w_sreg_nxt  = S;
          w_a_nxt     = '0;
          w_x_nxt     = 1'b0;
          w_count_nxt = '0;
          w_state_nxt = ADD;
        end
      end

      ADD: begin
        if (r_b[0]) begin
          {w_x_nxt, w_a_nxt} = w_sum;
        end
        w_state_nxt = SHIFT;
      end

      SHIFT: begin
        // Arithmetic shift keeps X (signed); logical shift clears it.
        w_x_nxt     = SIGNED ? r_x : 1'b0;
        w_a_nxt     = {r_x, r_a[WIDTH-1:1]};
        w_b_nxt     = {r_a[0], r_b[WIDTH-1:1]};
        w_count_nxt = w_count_inc;
        w_state_nxt = (w_count_inc == CW'(WIDTH)) ? DONE : ADD;
      end

      DONE: begin
        if (ClearA_LoadB) begin
          w_b_nxt = S;
          w_a_nxt = '0;
          w_x_nxt = 1'b0;
        end else if (!Run) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= 1'b0;
      r_sreg  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_x     <= w_x_nxt;
      r_sreg  <= w_sreg_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;
  assign Done = (r_state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
// Three instances (8-bit signed, 8-bit unsigned, 4-bit signed) share one set
// of inputs; each is checked against plain integer multiplication.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;

  logic [7:0] a8s, b8s, a8u, b8u;
  logic [3:0] a4s, b4s;
  logic       x8s, x8u, x4s;
  logic       d8s, d8u, d4s;

  int errors = 0;
  int checks = 0;

  // Expected register contents per instance.
  logic [7:0] m_a8s, m_b8s, m_a8u, m_b8u;
  logic [3:0] m_a4s, m_b4s;
  logic       m_x8s, m_x8u, m_x4s;

  always #5 Clk = ~Clk;

  shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S),
    .Aval(a8s), .Bval(b8s), .X(x8s), .Done(d8s)
  );

  shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S),
    .Aval(a8u), .Bval(b8u), .X(x8u), .Done(d8u)
  );

  shift_add_multiplier #(.WIDTH(4), .SIGNED(1'b1)) u_s4 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S[3:0]),
    .Aval(a4s), .Bval(b4s), .X(x4s), .Done(d4s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, " s8.A"}, 32'(a8s), 32'(m_a8s));
    check({tag, " s8.B"}, 32'(b8s), 32'(m_b8s));
    check({tag, " s8.X"}, 32'(x8s), 32'(m_x8s));
    check({tag, " u8.A"}, 32'(a8u), 32'(m_a8u));
    check({tag, " u8.B"}, 32'(b8u), 32'(m_b8u));
    check({tag, " u8.X"}, 32'(x8u), 32'(m_x8u));
    check({tag, " s4.A"}, 32'(a4s), 32'(m_a4s));
    check({tag, " s4.B"}, 32'(b4s), 32'(m_b4s));
    check({tag, " s4.X"}, 32'(x4s), 32'(m_x4s));
  endtask

  task automatic model_clear(input logic [7:0] b);
    logic [3:0] b4;
    b4    = b[3:0];
    m_b8s = b;
    m_b8u = b;
    m_b4s = b4;
    {m_a8s, m_a8u, m_a4s} = '0;
    {m_x8s, m_x8u, m_x4s} = '0;
  endtask

  // Product of the current B with s, as plain integers.
  task automatic model_mult(input logic [7:0] s);
    int         p;
    logic [3:0] s4;
    s4 = s[3:0];
    p = int'($signed(m_b8s)) * int'($signed(s));
    {m_a8s, m_b8s} = p[15:0];
    m_x8s = p[15];
    p = int'(m_b8u) * int'(s);
    {m_a8u, m_b8u} = p[15:0];
    m_x8u = 1'b0;
    p = int'($signed(m_b4s)) * int'($signed(s4));
    {m_a4s, m_b4s} = p[7:0];
    m_x4s = p[7];
  endtask

  task automatic do_load(input logic [7:0] s);
    S            = s;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    model_clear(s);
    check_all("load");
    check("load done", 32'(d8s), 32'd0);
  endtask

  // mode 1: ClearA_LoadB pulse + S change while in SHIFT; mode 2: S change
  // right after the start edge.
  task automatic do_run(input logic [7:0] s, input int mode);
    int         edge_n;
    int         e8s, e8u, e4s;
    logic [7:0] junk;
    model_mult(s);
    S   = s;
    Run = 1'b1;
    tick();
    edge_n = 1;
    e8s = 0;
    e8u = 0;
    e4s = 0;
    check("start done", 32'(d8s | d8u | d4s), 32'd0);
    while (edge_n < 40 && (e8s == 0 || e8u == 0 || e4s == 0)) begin
      junk = 8'($urandom);
      if (mode == 1 && edge_n == 2) begin
        ClearA_LoadB = 1'b1;
        S            = junk;
      end
      if (mode == 2 && edge_n == 1) S = junk;
      tick();
      edge_n++;
      ClearA_LoadB = 1'b0;
      if (d8s && e8s == 0) e8s = edge_n;
      if (d8u && e8u == 0) e8u = edge_n;
      if (d4s && e4s == 0) e4s = edge_n;
    end
    check("latency s8", 32'(e8s), 32'd17);
    check("latency u8", 32'(e8u), 32'd17);
    check("latency s4", 32'(e4s), 32'd9);
    check_all("result");
    // Holding Run must neither retrigger nor disturb the result.
    tick();
    tick();
    check("hold done", 32'({d8s, d8u, d4s}), 32'h7);
    check_all("hold");
    Run = 1'b0;
    tick();
    check("release done", 32'({d8s, d8u, d4s}), 32'h0);
  endtask

  initial begin
    logic [7:0] rs;
    logic [7:0] rb;
    logic [2:0] rc;

    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    S            = 8'h00;
    tick();
    tick();
    Reset = 1'b0;
    model_clear(8'h00);
    check_all("reset");
    check("reset done", 32'({d8s, d8u, d4s}), 32'h0);

    // Directed cases.
    do_load(8'h07);
    do_run(8'hFD, 0);
    check("dir -21 s8", 32'({x8s, a8s, b8s}), 32'h1FFEB);
    do_load(8'h80);
    do_run(8'h80, 0);
    check("dir 16384 s8", 32'({x8s, a8s, b8s}), 32'h04000);
    do_load(8'hFF);
    do_run(8'hFF, 0);
    check("dir 255x255 u8", 32'({x8u, a8u, b8u}), 32'h0FE01);
    do_load(8'h07);
    do_run(8'h08, 0);
    check("dir -56 s4", 32'({x4s, a4s, b4s}), 32'h1C8);

    // Chaining: previous low half becomes the next multiplier.
    do_load(8'h02);
    do_run(8'h03, 0);
    check("chain1 s8", 32'(b8s), 32'h06);
    do_run(8'h03, 0);
    check("chain2 s8", 32'({a8s, b8s}), 32'h0012);

    // Load has priority over Run in IDLE; no multiplication may start.
    S            = 8'h5A;
    ClearA_LoadB = 1'b1;
    Run          = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    Run          = 1'b0;
    model_clear(8'h5A);
    repeat (20) tick();
    check("prio done", 32'({d8s, d8u, d4s}), 32'h0);
    check_all("prio");

    // Robustness: ignored load during SHIFT, S changes mid-run.
    do_load(8'hC3);
    do_run(8'h6D, 1);
    do_load(8'h39);
    do_run(8'hA4, 2);

    // Reset sampled on edge 5 of a run aborts it.
    do_load(8'h9B);
    S   = 8'h77;
    Run = 1'b1;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Run   = 1'b0;
    model_clear(8'h00);
    check_all("abort");
    check("abort done", 32'({d8s, d8u, d4s}), 32'h0);
    tick();
    do_load(8'h0B);
    do_run(8'hF5, 0);

    // Randomized runs, sometimes chained, sometimes with disturbances.
    for (int i = 0; i < 12; i++) begin
      rs = 8'($urandom);
      rb = 8'($urandom);
      rc = 3'($urandom);
      if (rc[0]) do_load(rb);
      do_run(rs, int'(rc[2:1]) % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
